// File: rtl/fractal_nn_sequencer.sv
// Ternary-weight neuron sequencer: buffers N_INPUTS {x, w_zero, w_sign}
// elements, replays them onto the datapath strobes on start while keeping a
// saturating signed accumulator, and offers the result over valid/ready.
module fractal_nn_sequencer #(
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic                          ld_x,
    input  logic                          ld_w_zero,
    input  logic                          ld_w_sign,
    input  logic                          ld_clear,
    output logic [$clog2(N_INPUTS+1)-1:0] ld_count,
    input  logic                          start,
    output logic                          busy,
    output logic                          dp_en,
    output logic                          dp_clr,
    output logic                          dp_x,
    output logic                          dp_w_zero,
    output logic                          dp_w_sign,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_W-1:0]              res_data
);

    localparam int CW = $clog2(N_INPUTS + 1);
    localparam int IW = $clog2(N_INPUTS);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DONE
    } state_t;

    state_t                   state;
    logic [CW-1:0]            count;
    logic [IW-1:0]            step_idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]         res_q;
    logic [N_INPUTS-1:0]      buf_x;
    logic [N_INPUTS-1:0]      buf_wz;
    logic [N_INPUTS-1:0]      buf_ws;
    logic                     wr_en;
    logic [IW-1:0]            wr_idx;

    assign ld_ready  = (state == S_IDLE) || (state == S_LOAD);
    assign ld_count  = count;
    assign wr_en     = ld_valid && ld_ready && !ld_clear;
    assign wr_idx    = count[IW-1:0];
    assign dp_en     = (state == S_RUN) && ena && !ld_clear;
    assign dp_x      = dp_en & buf_x[step_idx];
    assign dp_w_zero = dp_en & buf_wz[step_idx];
    assign dp_w_sign = dp_en & buf_ws[step_idx];
    assign res_data  = res_q;

    // Element storage; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_x[wr_idx]  <= ld_x;
            buf_wz[wr_idx] <= ld_w_zero;
            buf_ws[wr_idx] <= ld_w_sign;
        end
    end

    // Saturating add of the current element's ternary product {-1, 0, +1}.
    always_comb begin
        acc_next = acc;
        if (buf_x[step_idx] && !buf_wz[step_idx]) begin
            if (buf_ws[step_idx]) begin
                if (acc != ACC_MIN) acc_next = acc - 1'b1;
            end else begin
                if (acc != ACC_MAX) acc_next = acc + 1'b1;
            end
        end
    end

    // Control FSM: load, wait for start, step elements, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            step_idx  <= '0;
            acc       <= '0;
            res_q     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            dp_clr    <= 1'b0;
        end else begin
            dp_clr <= 1'b0;
            if (ld_clear) begin
                state     <= S_IDLE;
                count     <= '0;
                busy      <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_LOAD: begin
                        if (ld_valid) begin
                            count <= count + CW'(1);
                            if (count == CW'(N_INPUTS - 1)) state <= S_READY;
                            else                             state <= S_LOAD;
                        end
                    end
                    S_READY: begin
                        if (start) begin
                            state    <= S_RUN;
                            dp_clr   <= 1'b1;
                            acc      <= '0;
                            step_idx <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (ena) begin
                            acc <= acc_next;
                            if (step_idx == IW'(N_INPUTS - 1)) begin
                                state     <= S_DONE;
                                res_q     <= acc_next;
                                busy      <= 1'b0;
                                res_valid <= 1'b1;
                            end else begin
                                step_idx <= step_idx + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (res_ready) begin
                            state     <= S_READY;
                            res_valid <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fractal_nn_sequencer.sv
// Randomized self-checking bench for fractal_nn_sequencer with a small
// accumulator so saturation is reachable. A cycle model built from the
// element list and a clamped integer sum checks every output each cycle.
module tb_fractal_nn_sequencer;

    localparam int N     = 10;
    localparam int ACC_W = 4;
    localparam int CW    = $clog2(N + 1);
    localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
    localparam int MINV  = -(1 << (ACC_W - 1));
    localparam int BOUND = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic          ld_x = 1'b0;
    logic          ld_w_zero = 1'b0;
    logic          ld_w_sign = 1'b0;
    logic          ld_clear = 1'b0;
    logic [CW-1:0] ld_count;
    logic          start = 1'b0;
    logic          busy;
    logic          dp_en;
    logic          dp_clr;
    logic          dp_x;
    logic          dp_w_zero;
    logic          dp_w_sign;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [ACC_W-1:0] res_data;

    int tests = 0;
    int fails = 0;

    // Model state: element list, running/done flags, clamped integer sum.
    bit m_x[N];
    bit m_wz[N];
    bit m_ws[N];
    int m_count = 0;
    bit m_run = 0;
    bit m_done = 0;
    int m_pos = 0;
    int m_sum = 0;
    int m_res = 0;
    bit m_clr = 0;

    fractal_nn_sequencer #(.N_INPUTS(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_x(ld_x), .ld_w_zero(ld_w_zero), .ld_w_sign(ld_w_sign),
        .ld_clear(ld_clear), .ld_count(ld_count),
        .start(start), .busy(busy),
        .dp_en(dp_en), .dp_clr(dp_clr), .dp_x(dp_x),
        .dp_w_zero(dp_w_zero), .dp_w_sign(dp_w_sign),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then model advance for the edge.
    always @(negedge clk) begin
        logic e_en;
        int   p;
        if (!rst_n) begin
            m_count = 0; m_run = 0; m_done = 0; m_pos = 0;
            m_sum = 0; m_res = 0; m_clr = 0;
            checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
            checkOutput("rst_ld_count", 32'(ld_count), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_dp_en", 32'(dp_en), 32'd0);
            checkOutput("rst_dp_clr", 32'(dp_clr), 32'd0);
            checkOutput("rst_dp_bits", 32'({dp_x, dp_w_zero, dp_w_sign}), 32'd0);
            checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
            checkOutput("rst_res_data", 32'(res_data), 32'd0);
        end else begin
            e_en = m_run && ena && !ld_clear;
            checkOutput("ld_ready", 32'(ld_ready), 32'(m_count < N));
            checkOutput("ld_count", 32'(ld_count), 32'(m_count));
            checkOutput("busy", 32'(busy), 32'(m_run));
            checkOutput("dp_en", 32'(dp_en), 32'(e_en));
            checkOutput("dp_clr", 32'(dp_clr), 32'(m_clr));
            checkOutput("dp_x", 32'(dp_x), 32'(e_en && m_x[m_pos]));
            checkOutput("dp_w_zero", 32'(dp_w_zero), 32'(e_en && m_wz[m_pos]));
            checkOutput("dp_w_sign", 32'(dp_w_sign), 32'(e_en && m_ws[m_pos]));
            checkOutput("res_valid", 32'(res_valid), 32'(m_done));
            checkOutput("res_data", 32'(res_data), 32'(m_res & ((1 << ACC_W) - 1)));

            m_clr = 0;
            if (ld_clear) begin
                m_count = 0; m_run = 0; m_done = 0;
            end else if (m_count < N) begin
                if (ld_valid) begin
                    m_x[m_count] = ld_x; m_wz[m_count] = ld_w_zero; m_ws[m_count] = ld_w_sign;
                    m_count++;
                end
            end else if (m_run) begin
                if (ena) begin
                    p = (!m_x[m_pos] || m_wz[m_pos]) ? 0 : (m_ws[m_pos] ? -1 : 1);
                    m_sum = m_sum + p;
                    if (m_sum > MAXV) m_sum = MAXV;
                    if (m_sum < MINV) m_sum = MINV;
                    m_pos++;
                    if (m_pos == N) begin
                        m_run = 0; m_done = 1; m_res = m_sum; m_pos = 0;
                    end
                end
            end else if (m_done) begin
                if (res_ready) m_done = 0;
            end else if (start) begin
                m_run = 1; m_pos = 0; m_sum = 0; m_clr = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the load port, run start/stall and result handshake patterns.
    task automatic applyStimulus(input string kind, input logic [N-1:0] x,
                                 input logic [N-1:0] wz, input logic [N-1:0] ws,
                                 input bit rnd, input int stall_at,
                                 input int exp_lat, output int lat);
        lat = 0;
        if (kind == "clear") begin
            ld_clear = 1'b1; tick(); ld_clear = 1'b0;
        end else if (kind == "load") begin
            for (int i = 0; i < N; i++) begin
                while (rnd && $urandom_range(0, 2) == 0) begin
                    ld_valid = 1'b0;
                    ld_x = 1'($urandom); ld_w_zero = 1'($urandom); ld_w_sign = 1'($urandom);
                    start = 1'($urandom);
                    tick();
                end
                start = 1'b0;
                ld_valid = 1'b1; ld_x = x[i]; ld_w_zero = wz[i]; ld_w_sign = ws[i];
                tick();
            end
            ld_valid = 1'b0;
        end else if (kind == "run") begin
            start = 1'b1; tick(); start = 1'b0; lat = 1;
            while (res_valid !== 1'b1 && lat < BOUND) begin
                if (rnd) ena = ($urandom_range(0, 2) != 0);
                else     ena = !(stall_at > 0 && lat >= stall_at && lat < stall_at + 3);
                tick(); lat++;
            end
            ena = 1'b1;
            checkOutput("result_seen", 32'(res_valid), 32'd1);
            if (exp_lat > 0) checkOutput("latency", 32'(lat), 32'(exp_lat));
        end else if (kind == "accept") begin
            res_ready = 1'b1; tick(); res_ready = 1'b0;
        end
    endtask

    initial begin
        int lat;
        logic [N-1:0] rx, rwz, rws;
        logic [3:0] saved;

        rst_n = 1'b0;
        #1;
        checkOutput("reset_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("reset_res_data", 32'(res_data), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // All {1,+1}: saturates at +7, result one cycle after the last element.
        applyStimulus("load", '1, '0, '0, 1'b0, 0, 0, lat);
        applyStimulus("run", '0, '0, '0, 1'b0, 0, N + 1, lat);
        checkOutput("sat_pos", 32'(res_data), 32'd7);
        applyStimulus("accept", '0, '0, '0, 1'b0, 0, 0, lat);

        // All {1,-1}: saturates at -8.
        applyStimulus("clear", '0, '0, '0, 1'b0, 0, 0, lat);
        applyStimulus("load", '1, '0, '1, 1'b1, 0, 0, lat);
        applyStimulus("run", '0, '0, '0, 1'b0, 0, N + 1, lat);
        checkOutput("sat_neg", 32'(res_data), 32'h8);
        applyStimulus("accept", '0, '0, '0, 1'b0, 0, 0, lat);

        // x={1,1,0,1}, w={-1,-1,+1,0}: -2.
        applyStimulus("clear", '0, '0, '0, 1'b0, 0, 0, lat);
        applyStimulus("load", 10'b0000001011, 10'b0000001000, 10'b0000000011, 1'b0, 0, 0, lat);
        applyStimulus("run", '0, '0, '0, 1'b0, 0, N + 1, lat);
        checkOutput("mixed", 32'(res_data), 32'hE);
        applyStimulus("accept", '0, '0, '0, 1'b0, 0, 0, lat);

        // Three stalled cycles mid-run push the result out by three cycles.
        applyStimulus("run", '0, '0, '0, 1'b0, 4, N + 4, lat);
        checkOutput("stall_same", 32'(res_data), 32'hE);

        // Result held under back-pressure; start and loads are ignored.
        saved = res_data;
        res_ready = 1'b0; start = 1'b1; ld_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_data", 32'(res_data), 32'(saved));
            checkOutput("hold_ld_ready", 32'(ld_ready), 32'd0);
        end
        start = 1'b0; ld_valid = 1'b0;
        applyStimulus("accept", '0, '0, '0, 1'b0, 0, 0, lat);
        applyStimulus("run", '0, '0, '0, 1'b0, 0, N + 1, lat);
        checkOutput("rerun", 32'(res_data), 32'hE);
        applyStimulus("accept", '0, '0, '0, 1'b0, 0, 0, lat);

        // Clear mid-run with a simultaneous load attempt.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        ld_clear = 1'b1; ld_valid = 1'b1; ld_x = 1'b1;
        tick();
        ld_clear = 1'b0; ld_valid = 1'b0;
        checkOutput("clr_count", 32'(ld_count), 32'd0);
        checkOutput("clr_ready", 32'(ld_ready), 32'd1);
        checkOutput("clr_busy", 32'(busy), 32'd0);
        repeat (N + 3) tick();

        // Asynchronous reset in the middle of a run.
        applyStimulus("load", '1, '0, '0, 1'b0, 0, 0, lat);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checkOutput("arst_dp_en", 32'(dp_en), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_count", 32'(ld_count), 32'd0);
        checkOutput("arst_res_data", 32'(res_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized runs: fresh or reused buffers, stalls, aborts, back-pressure.
        for (int it = 0; it < 40; it++) begin
            if (it == 0 || $urandom_range(0, 2) != 0 || ld_count != CW'(N)) begin
                applyStimulus("clear", '0, '0, '0, 1'b0, 0, 0, lat);
                rx = N'($urandom); rwz = N'($urandom); rws = N'($urandom);
                if ($urandom_range(0, 3) == 0) begin rx = '1; rwz = '0; end
                applyStimulus("load", rx, rwz, rws, 1'b1, 0, 0, lat);
            end
            if ($urandom_range(0, 7) == 0) begin
                start = 1'b1; tick(); start = 1'b0;
                repeat ($urandom_range(0, N)) begin
                    ena = 1'($urandom); tick();
                end
                ena = 1'b1;
                ld_clear = 1'b1; ld_valid = 1'($urandom); start = 1'($urandom);
                tick();
                ld_clear = 1'b0; ld_valid = 1'b0; start = 1'b0;
            end else begin
                applyStimulus("run", '0, '0, '0, 1'b1, 0, 0, lat);
                repeat ($urandom_range(0, 4)) begin
                    start = 1'($urandom); tick();
                end
                start = 1'b0;
                applyStimulus("accept", '0, '0, '0, 1'b0, 0, 0, lat);
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
